// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown timer for the microwave controller.
// Digits arrive from the keypad controller (digit/loadn/pgt), are shifted into
// a four-digit register, and are counted down once per second while RUNNING.
// The running/done outputs are decoded straight from the registered FSM state.

module countdown_timer #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       loadn,
    input  logic       pgt,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       done
);

    // Prescaler is wide enough to hold TICKS_PER_SEC-1; never narrower than one bit.
    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       min_tens_q, min_tens_d;
    logic [3:0]       min_units_q, min_units_d;
    logic [3:0]       sec_tens_q, sec_tens_d;
    logic [3:0]       sec_units_q, sec_units_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             pgt_q;

    logic             key_event;
    logic             key_valid;
    logic             time_zero;
    logic             tick;

    logic [3:0]       dec_min_tens;
    logic [3:0]       dec_min_units;
    logic [3:0]       dec_sec_tens;
    logic [3:0]       dec_sec_units;
    logic             dec_zero;

    // Key strobe: a rising edge of pgt while the controller holds loadn low.
    assign key_event = pgt & ~pgt_q & ~loadn;
    assign key_valid = key_event && (digit <= 4'd9);

    assign time_zero = (min_tens_q == 4'd0) && (min_units_q == 4'd0) &&
                       (sec_tens_q == 4'd0) && (sec_units_q == 4'd0);

    // The one-second tick only exists while the magnetron is on.
    assign tick = (state_q == ST_RUNNING) && (presc_q == LAST_TICK);

    // One-second BCD decrement of MM:SS with borrows rippling from seconds to minutes.
    always_comb begin
        dec_min_tens  = min_tens_q;
        dec_min_units = min_units_q;
        dec_sec_tens  = sec_tens_q;
        dec_sec_units = sec_units_q;
        if (sec_units_q != 4'd0) begin
            dec_sec_units = sec_units_q - 4'd1;
        end else begin
            dec_sec_units = 4'd9;
            if (sec_tens_q != 4'd0) begin
                dec_sec_tens = sec_tens_q - 4'd1;
            end else begin
                dec_sec_tens = 4'd5;
                if (min_units_q != 4'd0) begin
                    dec_min_units = min_units_q - 4'd1;
                end else begin
                    dec_min_units = 4'd9;
                    dec_min_tens  = min_tens_q - 4'd1;
                end
            end
        end
        dec_zero = (dec_min_tens == 4'd0) && (dec_min_units == 4'd0) &&
                   (dec_sec_tens == 4'd0) && (dec_sec_units == 4'd0);
    end

    // Next-state, time register and prescaler update; stop beats start, start beats key entry.
    always_comb begin
        state_d     = state_q;
        min_tens_d  = min_tens_q;
        min_units_d = min_units_q;
        sec_tens_d  = sec_tens_q;
        sec_units_d = sec_units_q;
        presc_d     = presc_q;

        case (state_q)
            ST_IDLE, ST_PAUSED: begin
                if (stop) begin
                    state_d     = ST_IDLE;
                    min_tens_d  = 4'd0;
                    min_units_d = 4'd0;
                    sec_tens_d  = 4'd0;
                    sec_units_d = 4'd0;
                end else if (start && !time_zero) begin
                    state_d = ST_RUNNING;
                    presc_d = '0;
                end else if (key_valid) begin
                    min_tens_d  = min_units_q;
                    min_units_d = sec_tens_q;
                    sec_tens_d  = sec_units_q;
                    sec_units_d = digit;
                end
            end

            ST_RUNNING: begin
                if (stop) begin
                    state_d = ST_PAUSED;
                end else if (tick) begin
                    presc_d = '0;
                    if (!time_zero) begin
                        min_tens_d  = dec_min_tens;
                        min_units_d = dec_min_units;
                        sec_tens_d  = dec_sec_tens;
                        sec_units_d = dec_sec_units;
                        if (dec_zero) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                if (start || stop || key_event) begin
                    state_d     = ST_IDLE;
                    min_tens_d  = 4'd0;
                    min_units_d = 4'd0;
                    sec_tens_d  = 4'd0;
                    sec_units_d = 4'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, time digits, prescaler and key-edge history with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            min_tens_q  <= 4'd0;
            min_units_q <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_units_q <= 4'd0;
            presc_q     <= '0;
            pgt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_tens_q  <= min_tens_d;
            min_units_q <= min_units_d;
            sec_tens_q  <= sec_tens_d;
            sec_units_q <= sec_units_d;
            presc_q     <= presc_d;
            pgt_q       <= pgt;
        end
    end

    assign min_tens  = min_tens_q;
    assign min_units = min_units_q;
    assign sec_tens  = sec_tens_q;
    assign sec_units = sec_units_q;
    assign running   = (state_q == ST_RUNNING);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vectors for countdown_timer with a 4-cycle second.
// A table covers digit entry and idle-state controls; hand-written sequences
// cover countdown, borrow, completion, pause/resume and reset mid-count.

module tb_countdown_timer;

    logic       clock;
    logic       reset;
    logic [3:0] digit;
    logic       loadn;
    logic       pgt;
    logic       start;
    logic       stop;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       running;
    logic       done;

    int n_checks;
    int n_fails;

    typedef struct {
        logic        rst;
        logic [3:0]  dig;
        logic        ldn;
        logic        pg;
        logic        sta;
        logic        sto;
        logic [15:0] exp_time;
        logic        exp_run;
        logic        exp_done;
    } vec_t;

    vec_t tbl[$];

    countdown_timer #(
        .TICKS_PER_SEC(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .digit     (digit),
        .loadn     (loadn),
        .pgt       (pgt),
        .start     (start),
        .stop      (stop),
        .min_tens  (min_tens),
        .min_units (min_units),
        .sec_tens  (sec_tens),
        .sec_units (sec_units),
        .running   (running),
        .done      (done)
    );

    // 10-time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs, let one rising edge pass, then settle before sampling.
    task automatic apply_stimulus(input logic rst, input logic [3:0] dig, input logic ldn,
                                  input logic pg, input logic sta, input logic sto);
        reset = rst;
        digit = dig;
        loadn = ldn;
        pgt   = pg;
        start = sta;
        stop  = sto;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Press and release one key; the digit is visible after the press edge.
    task automatic press_key(input logic [3:0] d);
        apply_stimulus(1'b0, d, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_output(input string name, input logic [15:0] exp_time,
                                input logic exp_run, input logic exp_done);
        logic [15:0] act_time;
        act_time = {min_tens, min_units, sec_tens, sec_units};
        n_checks++;
        if (act_time !== exp_time || running !== exp_run || done !== exp_done) begin
            n_fails++;
            $display("[TB] FAIL %s: got time=%h run=%b done=%b, expected time=%h run=%b done=%b",
                     name, act_time, running, done, exp_time, exp_run, exp_done);
        end
    endtask

    task automatic add_vec(input logic rst, input logic [3:0] dig, input logic ldn,
                           input logic pg, input logic sta, input logic sto,
                           input logic [15:0] t, input logic r, input logic d);
        vec_t v;
        v.rst = rst; v.dig = dig; v.ldn = ldn; v.pg = pg; v.sta = sta; v.sto = sto;
        v.exp_time = t; v.exp_run = r; v.exp_done = d;
        tbl.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1; digit = 4'd0; loadn = 1'b1; pgt = 1'b0; start = 1'b0; stop = 1'b0;

        // rst dig ldn pgt sta sto  time  run done
        add_vec(1, 4'd0,  1, 0, 0, 0, 16'h0000, 0, 0);
        add_vec(0, 4'd1,  0, 1, 0, 0, 16'h0001, 0, 0);
        add_vec(0, 4'd1,  1, 0, 0, 0, 16'h0001, 0, 0);
        add_vec(0, 4'd3,  0, 1, 0, 0, 16'h0013, 0, 0);
        add_vec(0, 4'd3,  1, 0, 0, 0, 16'h0013, 0, 0);
        add_vec(0, 4'd0,  0, 1, 0, 0, 16'h0130, 0, 0);
        add_vec(0, 4'd0,  1, 0, 0, 0, 16'h0130, 0, 0);
        add_vec(0, 4'd12, 0, 1, 0, 0, 16'h0130, 0, 0);
        add_vec(0, 4'd12, 1, 0, 0, 0, 16'h0130, 0, 0);
        add_vec(0, 4'd5,  1, 1, 0, 0, 16'h0130, 0, 0);
        add_vec(0, 4'd5,  0, 1, 0, 0, 16'h0130, 0, 0);
        add_vec(0, 4'd5,  1, 0, 0, 0, 16'h0130, 0, 0);
        add_vec(0, 4'd1,  0, 1, 0, 0, 16'h1301, 0, 0);
        add_vec(0, 4'd1,  1, 0, 0, 0, 16'h1301, 0, 0);
        add_vec(0, 4'd2,  0, 1, 0, 0, 16'h3012, 0, 0);
        add_vec(0, 4'd2,  1, 0, 0, 0, 16'h3012, 0, 0);
        add_vec(0, 4'd3,  0, 1, 0, 0, 16'h0123, 0, 0);
        add_vec(0, 4'd3,  1, 0, 0, 0, 16'h0123, 0, 0);
        add_vec(0, 4'd4,  0, 1, 0, 0, 16'h1234, 0, 0);
        add_vec(0, 4'd4,  1, 0, 0, 0, 16'h1234, 0, 0);
        add_vec(0, 4'd5,  0, 1, 0, 0, 16'h2345, 0, 0);
        add_vec(0, 4'd5,  1, 0, 0, 0, 16'h2345, 0, 0);
        add_vec(0, 4'd0,  1, 0, 0, 1, 16'h0000, 0, 0);
        add_vec(0, 4'd0,  1, 0, 1, 0, 16'h0000, 0, 0);
        add_vec(0, 4'd0,  1, 0, 0, 0, 16'h0000, 0, 0);

        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].rst, tbl[i].dig, tbl[i].ldn, tbl[i].pg, tbl[i].sta, tbl[i].sto);
            check_output($sformatf("vec%0d", i), tbl[i].exp_time, tbl[i].exp_run, tbl[i].exp_done);
        end

        // Countdown with seconds borrow from 01:00.
        press_key(4'd1); press_key(4'd0); press_key(4'd0);
        check_output("load_0100", 16'h0100, 0, 0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_output("start_running", 16'h0100, 1, 0);
        for (int i = 0; i < 3; i++) idle_cycle();
        check_output("before_first_tick", 16'h0100, 1, 0);
        idle_cycle();
        check_output("tick_0059", 16'h0059, 1, 0);
        for (int i = 0; i < 3; i++) idle_cycle();
        check_output("hold_0059", 16'h0059, 1, 0);
        idle_cycle();
        check_output("tick_0058", 16'h0058, 1, 0);

        // Pause, edit while paused, resume with a full second.
        idle_cycle();
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("pause_freeze", 16'h0058, 0, 0);
        for (int i = 0; i < 5; i++) idle_cycle();
        check_output("paused_hold", 16'h0058, 0, 0);
        press_key(4'd7);
        check_output("key7_paused", 16'h0587, 0, 0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_output("resume", 16'h0587, 1, 0);
        for (int i = 0; i < 3; i++) idle_cycle();
        check_output("resume_full_second", 16'h0587, 1, 0);
        idle_cycle();
        check_output("resume_tick", 16'h0586, 1, 0);
        press_key(4'd9);
        check_output("key_ignored_running", 16'h0586, 1, 0);

        // start and stop together while running: stop wins.
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_output("start_stop_pause", 16'h0586, 0, 0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_output("restart", 16'h0586, 1, 0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("stop_once", 16'h0586, 0, 0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("stop_twice_clear", 16'h0000, 0, 0);

        // Minute-tens borrow: 10:00 -> 09:59.
        press_key(4'd1); press_key(4'd0); press_key(4'd0); press_key(4'd0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle_cycle();
        check_output("tick_0959", 16'h0959, 1, 0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("clear_after_0959", 16'h0000, 0, 0);

        // Completion from 00:02.
        press_key(4'd2);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle_cycle();
        check_output("tick_0001", 16'h0001, 1, 0);
        for (int i = 0; i < 3; i++) idle_cycle();
        check_output("pre_done", 16'h0001, 1, 0);
        idle_cycle();
        check_output("done_edge", 16'h0000, 0, 1);
        idle_cycle();
        check_output("done_hold", 16'h0000, 0, 1);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_output("done_start_idle", 16'h0000, 0, 0);

        // A key in DONE clears without being entered.
        press_key(4'd1);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle_cycle();
        check_output("done_again", 16'h0000, 0, 1);
        press_key(4'd4);
        check_output("done_key_clear", 16'h0000, 0, 0);

        // Reset while running at 05:17.
        press_key(4'd5); press_key(4'd1); press_key(4'd7);
        check_output("load_0517", 16'h0517, 0, 0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_cycle();
        apply_stimulus(1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        check_output("reset_running", 16'h0000, 0, 0);
        idle_cycle();
        check_output("after_reset_idle", 16'h0000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
